// File: rtl/fifo_pkg.sv
// Shared FIFO constants: default data width and burst length used by the
// FIFO write side, the read controller and its output buffer.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int BURST_LEN_DEF  = 4;

  // Occupancy that the read side may reach once all outstanding reads land.
  localparam int OBUF_DEPTH = 2;

endpackage : fifo_pkg

// File: rtl/fifo_rd_obuf.sv
// Two-entry in-order output buffer for the FIFO read controller.
// Entry 0 is always the head, so the downstream data comes straight from a
// register; a pop shifts entry 1 forward. A simultaneous push and pop keeps
// the occupancy unchanged and preserves order.
module fifo_rd_obuf
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic                  head_valid,
  output logic [FIFO_WIDTH-1:0] head_data
);

  logic [FIFO_WIDTH-1:0] e0_r, e1_r;
  logic [FIFO_WIDTH-1:0] e0_nxt_s, e1_nxt_s;
  logic [1:0]            count_r, count_nxt_s;

  // Next-state of the buffer entries and occupancy for push/pop combinations.
  always_comb begin
    e0_nxt_s    = e0_r;
    e1_nxt_s    = e1_r;
    count_nxt_s = count_r;
    case ({push, pop})
      2'b10: begin
        count_nxt_s = count_r + 2'd1;
        if (count_r == 2'd0) begin
          e0_nxt_s = push_data;
        end else begin
          e1_nxt_s = push_data;
        end
      end
      2'b01: begin
        count_nxt_s = count_r - 2'd1;
        if (count_r == 2'd2) begin
          e0_nxt_s = e1_r;
        end else begin
          e0_nxt_s = e0_r;
        end
      end
      2'b11: begin
        count_nxt_s = count_r;
        if (count_r == 2'd2) begin
          e0_nxt_s = e1_r;
          e1_nxt_s = push_data;
        end else begin
          e0_nxt_s = push_data;
        end
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // Buffer storage and occupancy register; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_r    <= {FIFO_WIDTH{1'b0}};
      e1_r    <= {FIFO_WIDTH{1'b0}};
      count_r <= 2'd0;
    end else begin
      e0_r    <= e0_nxt_s;
      e1_r    <= e1_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign count      = count_r;
  assign head_valid = (count_r != 2'd0);
  assign head_data  = e0_r;

endmodule : fifo_rd_obuf

// File: rtl/fifo_read_ctrl.sv
// FIFO read controller: issues FIFO reads so that buffered plus in-flight
// data never exceeds two entries, streams the data downstream with
// valid/ready, and tags the last beat of every BURST_LEN-beat burst.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         fifo_empty,
  output logic                         fifo_r_en,
  input  logic [FIFO_WIDTH-1:0]        fifo_rdata,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [FIFO_WIDTH-1:0]        m_data,
  output logic                         m_last,
  output logic [$clog2(BURST_LEN)-1:0] beat_cnt,
  output logic                         idle
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  logic [1:0]            count_s;
  logic                  head_valid_s;
  logic [FIFO_WIDTH-1:0] head_data_s;
  logic                  pop_s;
  logic                  rd_s;
  logic [2:0]            occ_s;
  logic                  inflight_r;
  logic                  started_r;
  logic [CW-1:0]         beat_r;

  fifo_rd_obuf #(
    .FIFO_WIDTH (FIFO_WIDTH)
  ) u_obuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_r),
    .push_data  (fifo_rdata),
    .pop        (pop_s),
    .count      (count_s),
    .head_valid (head_valid_s),
    .head_data  (head_data_s)
  );

  // Read issue: only request while space remains after this cycle's pop,
  // and never in the first cycle after reset release.
  always_comb begin
    pop_s = head_valid_s & m_ready;
    occ_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (started_r && en && !fifo_empty && (occ_s < 3'(OBUF_DEPTH))) begin
      rd_s = 1'b1;
    end else begin
      rd_s = 1'b0;
    end
  end

  // In-flight read flag, post-reset start flag and wrapping beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= 1'b0;
      started_r  <= 1'b0;
      beat_r     <= {CW{1'b0}};
    end else begin
      inflight_r <= rd_s;
      started_r  <= 1'b1;
      if (pop_s) begin
        if (beat_r == LAST_BEAT) begin
          beat_r <= {CW{1'b0}};
        end else begin
          beat_r <= beat_r + CW'(1);
        end
      end else begin
        beat_r <= beat_r;
      end
    end
  end

  assign fifo_r_en = rd_s;
  assign m_valid   = head_valid_s;
  assign m_data    = head_data_s;
  assign m_last    = head_valid_s & (beat_r == LAST_BEAT);
  assign beat_cnt  = beat_r;
  assign idle      = ~head_valid_s & ~inflight_r & ~en;

endmodule : fifo_read_ctrl

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: a queue models the FIFO, every word
// written is also queued as expected output, and a monitor pops and compares
// on every downstream handshake using a beat index counted since reset.
module tb_fifo_read_ctrl;

  localparam int W  = 8;
  localparam int BL = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic                   fifo_empty = 1'b1;
  logic                   fifo_r_en;
  logic [W-1:0]           fifo_rdata = '0;
  logic                   m_valid;
  logic                   m_ready = 1'b0;
  logic [W-1:0]           m_data;
  logic                   m_last;
  logic [$clog2(BL)-1:0]  beat_cnt;
  logic                   idle;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_err = 0;
  int pops = 0;
  int exp_beat = 0;
  logic [W-1:0] last_pop_data = '0;
  logic last_pop_last = 1'b0;
  int last_pop_beat = 0;

  fifo_read_ctrl #(.FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .beat_cnt   (beat_cnt),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample the read request mid-cycle, then deliver FIFO data.
  task automatic step();
    logic rd;
    @(negedge clk);
    rd = fifo_r_en;
    if (rd) begin
      check("rd_not_empty", {31'd0, fifo_empty}, 32'd0);
      check("rd_needs_en", {31'd0, en}, 32'd1);
    end
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() != 0) fifo_rdata = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic drain(input string nm);
    for (int g = 0; g < 3000 && exp_q.size() != 0; g++) step();
    check(nm, exp_q.size(), 0);
  endtask

  // Monitor / scoreboard: compare every beat and enforce stall stability.
  initial begin
    logic hold;
    logic [W-1:0] hold_data;
    logic hold_last;
    logic [W-1:0] d;
    hold = 1'b0;
    hold_data = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_beat = 0;
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", {31'd0, m_valid}, 32'd1);
          check("hold_data", {24'd0, m_data}, {24'd0, hold_data});
          check("hold_last", {31'd0, m_last}, {31'd0, hold_last});
        end
        if (m_valid) begin
          check("beat_cnt", {30'd0, beat_cnt}, exp_beat % BL);
          check("m_last", {31'd0, m_last}, {31'd0, ((exp_beat % BL) == BL - 1)});
        end else begin
          check("m_last_idle", {31'd0, m_last}, 32'd0);
        end
        if (m_valid && m_ready) begin
          check("beat_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
          if (exp_q.size() != 0) begin
            d = exp_q.pop_front();
            check("m_data", {24'd0, m_data}, {24'd0, d});
          end
          last_pop_data = m_data;
          last_pop_last = m_last;
          last_pop_beat = int'(beat_cnt);
          pops++;
          exp_beat++;
        end
        hold = m_valid && !m_ready;
        hold_data = m_data;
        hold_last = m_last;
      end
    end
  end

  // Directed scenarios followed by a long randomized run.
  initial begin
    int p0;
    // Reset state
    step();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_beat_cnt", {30'd0, beat_cnt}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    en = 1'b1;
    m_ready = 1'b1;
    #1;
    check("rst_r_en", {31'd0, fifo_r_en}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("first_cycle_r_en", {31'd0, fifo_r_en}, 32'd0);

    // Streaming: 8 beats on consecutive cycles
    for (int g = 0; g < 20 && pops == 0; g++) step();
    for (int i = 0; i < 7; i++) step();
    check("stream_no_bubble", pops, 8);
    check("stream_last_data", {24'd0, last_pop_data}, 32'h08);

    // Backpressure mid-stream
    for (int i = 0; i < 8; i++) push_word(W'(8'h11 + i));
    p0 = pops;
    for (int g = 0; g < 20 && pops < p0 + 2; g++) step();
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 5; i++) step();
    check("bp_no_pop", pops, p0);
    check("bp_r_en_low", {31'd0, fifo_r_en}, 32'd0);
    check("bp_valid", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1;
    drain("bp_drain");

    // Underflow mid-burst
    p0 = pops;
    for (int i = 0; i < 3; i++) push_word(W'(8'h31 + i));
    drain("uf_drain");
    step();
    step();
    check("uf_beats", pops - p0, 3);
    check("uf_valid_low", {31'd0, m_valid}, 32'd0);
    check("uf_beat_cnt", {30'd0, beat_cnt}, 32'd3);
    push_word(8'h34);
    drain("uf_resume");
    check("uf_resume_last", {31'd0, last_pop_last}, 32'd1);

    // Enable drop during streaming
    for (int i = 0; i < 8; i++) push_word(W'(8'h41 + i));
    p0 = pops;
    for (int g = 0; g < 20 && pops < p0 + 2; g++) step();
    en = 1'b0;
    p0 = pops;
    for (int i = 0; i < 6; i++) step();
    check("en_drop_max2", {31'd0, (pops - p0 <= 2)}, 32'd1);
    check("en_drop_idle", {31'd0, idle}, 32'd1);
    check("en_drop_r_en", {31'd0, fifo_r_en}, 32'd0);
    en = 1'b1;
    drain("en_drop_drain");

    // Mid-operation reset with buffered data
    for (int i = 0; i < 6; i++) push_word(W'(8'h51 + i));
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mr_setup_valid", {31'd0, m_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_m_valid", {31'd0, m_valid}, 32'd0);
    check("mr_m_data", {24'd0, m_data}, 32'd0);
    check("mr_beat_cnt", {30'd0, beat_cnt}, 32'd0);
    check("mr_r_en", {31'd0, fifo_r_en}, 32'd0);
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    push_word(8'hA0);
    m_ready = 1'b1;
    drain("mr_drain");
    check("mr_first_data", {24'd0, last_pop_data}, 32'hA0);
    check("mr_first_beat", last_pop_beat, 0);

    // Random ready/empty toggling
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 2) == 0) push_word(W'($urandom));
      m_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    m_ready = 1'b1;
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_fifo_read_ctrl
